// File: rtl/led_ring_ctrl.sv
// One-hot LED ring rotator driven by two debounced push-buttons: one reverses
// the rotation direction, the other pauses and resumes it.
module led_ring_ctrl #(
  parameter int WIDTH      = 8,
  parameter int TICK_COUNT = 50000000,
  parameter int DEBOUNCE   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_dir,
  input  logic             btn_pause,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             paused
);

  localparam int TW = $clog2(TICK_COUNT);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

  // Bit 0 carries the direction button, bit 1 the pause button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    hist_q;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];

  logic [WIDTH-1:0] led_q, led_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             dir_q, dir_d;
  logic             paused_q, paused_d;
  logic             step;

  assign btn_raw = {btn_pause, btn_dir};

  // Level is accepted only after DEBOUNCE consecutive edges disagree with it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    press = stable_q & ~hist_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      hist_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      hist_q      <= stable_q;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // Steps and the rotation use the current dir/paused, so a press landing on
  // a step edge only takes effect from the following cycle.
  always_comb begin
    step   = 1'b0;
    tick_d = tick_q;
    if (!paused_q) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        step   = 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end

    led_d = led_q;
    if (step) begin
      if (dir_q) begin
        led_d = {led_q[0], led_q[WIDTH-1:1]};
      end else begin
        led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      end
    end

    dir_d    = dir_q ^ press[0];
    paused_d = paused_q ^ press[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= WIDTH'(1);
      tick_q   <= '0;
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      led_q    <= led_d;
      tick_q   <= tick_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
    end
  end

  assign led    = led_q;
  assign dir    = dir_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_ring_ctrl.sv
// Directed bench for led_ring_ctrl with WIDTH=8, TICK_COUNT=4, DEBOUNCE=3;
// edge numbers below count rising edges since the last reset release.
module tb_led_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_dir = 1'b0;
  logic       btn_pause = 1'b0;
  logic [7:0] led;
  logic       dir;
  logic       paused;

  int compared = 0;
  int mismatched = 0;
  int edge_no = 0;

  led_ring_ctrl #(
    .WIDTH(8),
    .TICK_COUNT(4),
    .DEBOUNCE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_dir(btn_dir),
    .btn_pause(btn_pause),
    .led(led),
    .dir(dir),
    .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic d, input logic p);
    btn_dir   = d;
    btn_pause = p;
  endtask

  // Advance to just after the given rising edge (sampled on the falling edge).
  task automatic waitTo(input int target);
    while (edge_no < target) begin
      @(negedge clk);
      edge_no++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_led,
                             input logic exp_dir, input logic exp_paused);
    compared++;
    assert (led === exp_led) else begin
      mismatched++;
      $error("[TB] FAIL %s led: got %h expected %h", tag, led, exp_led);
    end
    compared++;
    assert (dir === exp_dir) else begin
      mismatched++;
      $error("[TB] FAIL %s dir: got %b expected %b", tag, dir, exp_dir);
    end
    compared++;
    assert (paused === exp_paused) else begin
      mismatched++;
      $error("[TB] FAIL %s paused: got %b expected %b", tag, paused, exp_paused);
    end
  endtask

  initial begin
    int hold;
    logic [7:0] exp_led;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1 checkOutput("reset_async", 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_no = 0;

    // Free run: one step every 4 edges, upward.
    for (int k = 1; k <= 40; k++) begin
      waitTo(k);
      exp_led = 8'h01 << ((k / 4) % 8);
      checkOutput($sformatf("freerun_e%0d", k), exp_led, 1'b0, 1'b0);
    end

    // Direction press sampled at edges 41..50, toggle lands at edge 46.
    applyStimulus(1'b1, 1'b0);
    waitTo(43); checkOutput("dir_wait43", 8'h04, 1'b0, 1'b0);
    waitTo(44); checkOutput("dir_step44", 8'h08, 1'b0, 1'b0);
    waitTo(45); checkOutput("dir_wait45", 8'h08, 1'b0, 1'b0);
    waitTo(46); checkOutput("dir_toggle46", 8'h08, 1'b1, 1'b0);
    waitTo(48); checkOutput("dir_down48", 8'h04, 1'b1, 1'b0);
    waitTo(50);
    applyStimulus(1'b0, 1'b0);
    waitTo(52); checkOutput("dir_down52", 8'h02, 1'b1, 1'b0);
    waitTo(56); checkOutput("dir_down56", 8'h01, 1'b1, 1'b0);
    waitTo(60); checkOutput("dir_wrap60", 8'h80, 1'b1, 1'b0);
    waitTo(64); checkOutput("dir_release64", 8'h40, 1'b1, 1'b0);

    // Two-cycle glitch on pause is rejected.
    applyStimulus(1'b0, 1'b1);
    waitTo(66);
    applyStimulus(1'b0, 1'b0);
    waitTo(68); checkOutput("glitch68", 8'h20, 1'b1, 1'b0);
    waitTo(72); checkOutput("glitch72", 8'h10, 1'b1, 1'b0);

    // Six-cycle pause press sampled 73..78; paused at 78 with counter at 2.
    applyStimulus(1'b0, 1'b1);
    waitTo(76); checkOutput("pause_step76", 8'h08, 1'b1, 1'b0);
    waitTo(77); checkOutput("pause_wait77", 8'h08, 1'b1, 1'b0);
    waitTo(78); checkOutput("pause_on78", 8'h08, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    waitTo(88); checkOutput("pause_hold88", 8'h08, 1'b1, 1'b1);
    waitTo(98); checkOutput("pause_hold98", 8'h08, 1'b1, 1'b1);

    // Resume press sampled 99..104; two running edges remain before the step.
    applyStimulus(1'b0, 1'b1);
    waitTo(103); checkOutput("resume_wait103", 8'h08, 1'b1, 1'b1);
    waitTo(104); checkOutput("resume104", 8'h08, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitTo(105); checkOutput("resume_count105", 8'h08, 1'b1, 1'b0);
    waitTo(106); checkOutput("resume_step106", 8'h04, 1'b1, 1'b0);

    // Turn direction back up (toggle at 112), then a press landing on step 122.
    applyStimulus(1'b1, 1'b0);
    waitTo(110); checkOutput("redir110", 8'h02, 1'b1, 1'b0);
    waitTo(112); checkOutput("redir112", 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitTo(114); checkOutput("up114", 8'h04, 1'b0, 1'b0);
    waitTo(116);
    applyStimulus(1'b1, 1'b0);
    waitTo(118); checkOutput("up118", 8'h08, 1'b0, 1'b0);
    waitTo(121); checkOutput("onstep_before121", 8'h08, 1'b0, 1'b0);
    waitTo(122); checkOutput("onstep122", 8'h10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitTo(126); checkOutput("onstep_next126", 8'h08, 1'b1, 1'b0);

    // Pause with led=0x20 and dir=1, then reset mid-debounce of the release.
    waitTo(146);
    applyStimulus(1'b0, 1'b1);
    waitTo(150); checkOutput("prerst150", 8'h20, 1'b1, 1'b0);
    waitTo(152); checkOutput("prerst152", 8'h20, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    waitTo(154); checkOutput("prerst154", 8'h20, 1'b1, 1'b1);
    rst = 1'b1;
    #1 checkOutput("midrun_reset", 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    edge_no = 0;
    waitTo(3); checkOutput("after_rst3", 8'h01, 1'b0, 1'b0);
    waitTo(4); checkOutput("after_rst4", 8'h02, 1'b0, 1'b0);

    // Both buttons together, sampled 5..10: both toggle at edge 10.
    applyStimulus(1'b1, 1'b1);
    waitTo(9);  checkOutput("both_wait9", 8'h04, 1'b0, 1'b0);
    waitTo(10); checkOutput("both10", 8'h04, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    waitTo(20); checkOutput("both_hold20", 8'h04, 1'b1, 1'b1);

    // Random button streams with rare reset pulses; led must stay one-hot.
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold == 0) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        hold = $urandom_range(1, 8);
      end
      hold--;
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      compared++;
      assert ($onehot(led)) else begin
        mismatched++;
        $error("[TB] FAIL onehot cycle %0d: got %h expected one bit set", c, led);
      end
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
